// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RISC-V ALU decode feeding a 2-entry valid/ready skid buffer toward execute
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     funct7_5,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_illegal,
  output logic [CNT_WIDTH-1:0]     illegal_cnt
);
  localparam int EW = 1 + OPCODE_LENGTH + 2 * DATA_WIDTH;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
  occ_t state_q, state_d;
  logic [EW-1:0] main_q, main_d, skid_q, skid_d, dec;
  logic in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0] alu_op, br_op, op;
  logic [DATA_WIDTH-1:0] src_a, src_b;
  logic ill, accept, pop;
  // opcode[5] separates R-type (sub allowed) from I-type (funct7_5 ignored for add)
  always_comb begin
    alu_op = funct3 == 3'b000 ? {3'b000, funct7_5 & opcode[5]} :
             funct3 == 3'b100 ? 4'h2 :
             funct3 == 3'b110 ? 4'h3 :
             funct3 == 3'b111 ? 4'h4 :
             funct3 == 3'b010 ? 4'h5 :
             funct3 == 3'b101 ? (funct7_5 ? 4'h6 : 4'h7) :
             funct3 == 3'b001 ? 4'h8 : 4'hf;
    br_op = funct3 == 3'b000 ? 4'hd :
            funct3 == 3'b001 ? 4'ha :
            funct3 == 3'b100 ? 4'hb :
            funct3 == 3'b101 ? 4'hc : 4'hf;
    op = opcode == 7'b0110011 || opcode == 7'b0010011 ? alu_op :
         opcode == 7'b0000011 || opcode == 7'b0100011 ? 4'h9 :
         opcode == 7'b1100011 ? br_op :
         opcode == 7'b0110111 ? 4'he : 4'hf;
    ill = op == 4'hf;
    src_a = ill || opcode == 7'b0110111 ? '0 : rs1_data;
    src_b = ill ? '0 : opcode == 7'b0110011 || opcode == 7'b1100011 ? rs2_data : imm;
    dec = {ill, OPCODE_LENGTH'(op), src_a, src_b};
  end
  always_comb begin
    accept = in_valid & in_ready_q;
    pop = out_valid & out_ready;
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    cnt_d = pop && out_illegal && !flush && cnt_q != '1 ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    case (state_q)
      EMPTY: if (accept) begin
        main_d = dec;
        state_d = ONE;
      end
      ONE: if (accept && pop) main_d = dec;
      else if (accept) begin
        skid_d = dec;
        state_d = TWO;
      end
      else if (pop) state_d = EMPTY;
      TWO: if (pop) begin
        main_d = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    in_ready_d = state_d != TWO;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      main_q <= main_d;
      skid_q <= skid_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign {out_illegal, Operation, SrcA, SrcB} = main_q;
  assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random checks of alu_issue_stage against a queue-based model
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, funct7_5 = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0;
  logic in_ready, out_valid, out_illegal;
  logic [31:0] SrcA, SrcB;
  logic [3:0] Operation;
  logic [3:0] illegal_cnt;
  int n_chk = 0, n_pass = 0;
  typedef struct packed {logic ill; logic [3:0] op; logic [31:0] a; logic [31:0] b;} ent_t;
  ent_t q[$];
  logic m_rdy = 1'b1;
  logic [3:0] m_cnt = '0;
  logic [3:0] tbl [8] = '{4'd0, 4'd8, 4'd5, 4'd15, 4'd2, 4'd7, 4'd3, 4'd4};
  logic [6:0] opc_pool [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6f, 7'h00};
  always #5 clk = ~clk;
  alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  function automatic ent_t ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    ent_t e;
    e.a = r1;
    e.b = im;
    e.ill = 1'b0;
    if (opc == 7'h33 || opc == 7'h13) begin
      e.op = tbl[f3];
      if (opc == 7'h33) e.b = r2;
      if (f3 == 3'd0 && opc == 7'h33 && f7) e.op = 4'd1;
      if (f3 == 3'd5 && f7) e.op = 4'd6;
    end else if (opc == 7'h03 || opc == 7'h23) e.op = 4'd9;
    else if (opc == 7'h63) begin
      e.b = r2;
      e.op = f3 == 3'd0 ? 4'd13 : f3 == 3'd1 ? 4'd10 : f3 == 3'd4 ? 4'd11 : f3 == 3'd5 ? 4'd12 : 4'd15;
    end else if (opc == 7'h37) begin
      e.a = '0;
      e.op = 4'd14;
    end else e.op = 4'd15;
    if (e.op == 4'd15) begin
      e.ill = 1'b1;
      e.a = '0;
      e.b = '0;
    end
    return e;
  endfunction
  task automatic model_step();
    logic acc;
    acc = in_valid & m_rdy;
    if (flush) q.delete();
    else begin
      if (out_ready && q.size() != 0) begin
        if (q[0].ill && m_cnt != 4'hf) m_cnt++;
        void'(q.pop_front());
      end
      if (acc) q.push_back(ref_dec(opcode, funct3, funct7_5, rs1_data, rs2_data, imm));
    end
    m_rdy = q.size() < 2;
  endtask
  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
    if (q.size() != 0) begin
      chk("SrcA", SrcA, q[0].a);
      chk("SrcB", SrcB, q[0].b);
      chk("Operation", 32'(Operation), 32'(q[0].op));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
  endtask
  task automatic cyc(input logic iv, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                     input logic ordy, input logic fl);
    in_valid = iv; opcode = opc; funct3 = f3; funct7_5 = f7;
    rs1_data = r1; rs2_data = r2; imm = im; out_ready = ordy; flush = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    q.delete();
    m_rdy = 1'b1;
    m_cnt = '0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_SrcA", SrcA, 32'd0);
    chk("rst_SrcB", SrcB, 32'd0);
    chk("rst_Operation", 32'(Operation), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 7'h33, 3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 1'b1, 1'b0);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_op", 32'(Operation), 32'd1);
    chk("sub_a", SrcA, 32'd10);
    chk("sub_b", SrcB, 32'd3);
    cyc(1'b1, 7'h13, 3'd5, 1'b1, 32'd77, 32'd9, 32'd4, 1'b1, 1'b0);
    chk("srai_op", 32'(Operation), 32'd6);
    chk("srai_b", SrcB, 32'd4);
    cyc(1'b1, 7'h13, 3'd0, 1'b1, 32'd5, 32'd9, 32'd7, 1'b1, 1'b0);
    chk("addi_op", 32'(Operation), 32'd0);
    cyc(1'b1, 7'h63, 3'd1, 1'b0, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
    chk("bne_op", 32'(Operation), 32'd10);
    cyc(1'b1, 7'h63, 3'd5, 1'b0, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0);
    chk("bge_op", 32'(Operation), 32'd12);
    cyc(1'b1, 7'h37, 3'd0, 1'b0, 32'hdead, 32'd2, 32'h12345000, 1'b1, 1'b0);
    chk("lui_op", 32'(Operation), 32'd14);
    chk("lui_a", SrcA, 32'd0);
    chk("lui_b", SrcB, 32'h12345000);
    cyc(1'b0, 7'h33, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cyc(1'b1, 7'h33, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 7'h33, 3'd0, 1'b0, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_a", SrcA, 32'd1);
    cyc(1'b1, 7'h33, 3'd0, 1'b0, 32'd3, 32'd1, 32'd0, 1'b0, 1'b0);
    chk("bp_hold_a2", SrcA, 32'd1);
    cyc(1'b0, 7'h33, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_second", SrcA, 32'd2);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    cyc(1'b0, 7'h33, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_drained", 32'(out_valid), 32'd0);
    do_reset();
    cyc(1'b1, 7'h6f, 3'd0, 1'b0, 32'd5, 32'd6, 32'd7, 1'b0, 1'b0);
    cyc(1'b1, 7'h33, 3'd3, 1'b0, 32'd5, 32'd6, 32'd7, 1'b0, 1'b0);
    chk("ill_op", 32'(Operation), 32'd15);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_a", SrcA, 32'd0);
    cyc(1'b0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("ill2_op", 32'(Operation), 32'd15);
    cyc(1'b0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("ill_cnt2", 32'(illegal_cnt), 32'd2);
    for (int i = 0; i < 20; i++) cyc(1'b1, 7'h7f, 3'd0, 1'b0, 32'd1, 32'd1, 32'd1, 1'b1, 1'b0);
    cyc(1'b0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("ill_sat", 32'(illegal_cnt), 32'd15);
    cyc(1'b1, 7'h33, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 7'h33, 3'd0, 1'b0, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 7'h33, 3'd0, 1'b0, 32'd3, 32'd1, 32'd0, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    cyc(1'b0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_dropped", 32'(out_valid), 32'd0);
    cyc(1'b1, 7'h33, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 7'h33, 3'd0, 1'b0, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom), opc_pool[3'($urandom)], 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU interface: decodes RISC-V instruction fields into the 4-bit ALU Operation code and selects SrcA/SrcB.
- Holds the results in a 2-entry valid/ready skid buffer between decode and execute.
- The ALU consumes SrcA, SrcB and Operation directly from this block's outputs.
- Flags unsupported instructions and counts them.

Parameters:
DATA_WIDTH, 32, operand width
OPCODE_LENGTH, 4, ALU Operation code width
CNT_WIDTH, 16, width of the illegal-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset
in_valid  input  1  upstream entry valid
in_ready  output  1  block can accept an entry (registered)
opcode  input  7  instruction[6:0]
funct3  input  3  instruction[14:12]
funct7_5  input  1  instruction[30]
rs1_data  input  DATA_WIDTH  register operand 1
rs2_data  input  DATA_WIDTH  register operand 2
imm  input  DATA_WIDTH  sign-extended immediate from the immediate generator
flush  input  1  synchronous pipeline flush
out_valid  output  1  SrcA/SrcB/Operation valid
out_ready  input  1  execute stage accepts
SrcA  output  DATA_WIDTH  ALU operand A
SrcB  output  DATA_WIDTH  ALU operand B
Operation  output  OPCODE_LENGTH  ALU operation code
out_illegal  output  1  head entry is an unsupported encoding
illegal_cnt  output  CNT_WIDTH  saturating count of illegal entries issued

Behaviour:
- Reset (reset=0, asynchronous): both entries empty; out_valid=0; in_ready=1; SrcA=SrcB=0; Operation=4'b0000; out_illegal=0; illegal_cnt=0.
- Decode is combinational on input fields and is captured on accept (in_valid & in_ready). Default SrcA=rs1_data.
- Opcode 0110011 (R-type), SrcB=rs2_data. funct3 mapping:
  - 000: funct7_5 ? 0001 (sub) : 0000 (add)
  - 100: 0010 (xor); 110: 0011 (or); 111: 0100 (and)
  - 010: 0101 (slt)
  - 101: funct7_5 ? 0110 (sra) : 0111 (srl)
  - 001: 1000 (sll)
  - 011: illegal
- Opcode 0010011 (I-type ALU), SrcB=imm. Same funct3 map as R-type, except:
  - 000 is always 0000 (addi); funct7_5 ignored.
  - Shifts 101/001 use imm; funct7_5 selects srai/srli.
- Opcode 0000011 (load) and 0100011 (store): Operation=1001, SrcB=imm.
- Opcode 1100011 (branch), SrcB=rs2_data. funct3 mapping:
  - 000: 1101 (beq); 001: 1010 (bne); 100: 1011 (blt); 101: 1100 (bge)
  - any other funct3: illegal
- Opcode 0110111 (LUI): Operation=1110, SrcB=imm, SrcA=0.
- Any other opcode is illegal.
- Illegal entries: Operation=1111, SrcA=SrcB=0, illegal bit=1. Illegal entries still flow through the handshake; they are never dropped.
- Buffer: main (output) entry plus skid entry; occupancy states EMPTY, ONE, TWO.
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> TWO; pop & !accept -> EMPTY; accept & pop -> ONE (new entry in main).
  - TWO: pop -> ONE (skid moves to main); no accept possible.
  - pop = out_valid & out_ready.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- out_valid = occupancy != EMPTY. Outputs are driven only from the main entry.
- Latency: accept at edge N gives out_valid at N+1 if the buffer was empty.
- Ordering is strictly FIFO.
- SrcA/SrcB/Operation/out_illegal hold stable while out_valid=1 and out_ready=0.
- illegal_cnt increments on a pop with out_illegal=1 and saturates at all-ones.
- flush=1: next edge → EMPTY, in_ready=1. Any same-cycle accept is discarded and any same-cycle pop is not counted. illegal_cnt is unaffected.
- Reset asserted mid-transfer clears everything immediately, independent of clk.

Test Plan:
- add x: opcode=0110011, funct3=000, funct7_5=1, rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, Operation=0001, SrcA=10, SrcB=3.
- addi/srai: opcode=0010011, funct3=101, funct7_5=1, imm=4 -> Operation=0110, SrcB=4. Same with funct3=000, funct7_5=1 -> Operation=0000.
- Branch/LUI: funct3=001 branch -> 1010; funct3=101 -> 1100; LUI imm=0x12345000 -> Operation=1110, SrcA=0, SrcB=0x12345000.
- Backpressure: out_ready=0, issue 3 back-to-back entries -> first two accepted, in_ready=0 after the second, outputs stable. Release out_ready -> entries emerge in order; in_ready returns to 1 one cycle after the first pop.
- Illegal: opcode=1101111 then opcode=0110011 with funct3=011 -> both emerge with Operation=1111, out_illegal=1; illegal_cnt=2 after both pops. Preload 0xFFFF -> counter stays at 0xFFFF.
- Flush/reset: fill to TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, input dropped. Drop reset mid-stream -> out_valid=0 with no clock edge.
